// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter letting several masters share one slave. The grant is held for a
// whole bus cycle, and a watchdog aborts any transfer that the slave never answers.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        busy_o
);
    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [IW-1:0] next_owner;
    logic [IW-1:0] scan_idx;
    logic [CW-1:0] wd_cnt;
    logic          own_cyc;
    logic          own_stb;
    logic          slave_resp;
    logic          wd_hit;

    assign own_cyc    = m_cyc_i[owner];
    assign own_stb    = m_stb_i[owner];
    assign slave_resp = s_ack_i | s_err_i | s_rty_i;
    assign wd_hit     = (TIMEOUT != 0) && (wd_cnt == CNT_LIMIT);

    // Scan from farthest to nearest so the requester closest after `last` is written last and wins.
    always_comb begin
        next_owner = last;
        scan_idx   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            scan_idx = IW'((int'(last) + i) % NUM_MASTERS);
            if (m_cyc_i[scan_idx]) next_owner = scan_idx;
        end
    end

    // NOTE: every output gets a default before the state-dependent overrides so no latch is inferred.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state == ACTIVE) begin
            s_adr_o = m_adr_i[int'(owner)*AW +: AW];
            s_dat_o = m_dat_i[int'(owner)*DW +: DW];
            s_sel_o = m_sel_i[int'(owner)*SW +: SW];
            s_we_o  = m_we_i[owner];
            s_cti_o = m_cti_i[int'(owner)*3 +: 3];
            s_bte_o = m_bte_i[int'(owner)*2 +: 2];
            s_cyc_o = own_cyc & ~wd_hit;
            s_stb_o = own_stb & ~wd_hit;
            m_dat_o = s_dat_i;
            if (wd_hit) begin
                m_err_o = grant_o;
            end else begin
                m_ack_o = grant_o & {NUM_MASTERS{s_ack_i}};
                m_err_o = grant_o & {NUM_MASTERS{s_err_i}};
                m_rty_o = grant_o & {NUM_MASTERS{s_rty_i}};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state   <= IDLE;
            owner   <= '0;
            last    <= IW'(NUM_MASTERS - 1);
            grant_o <= '0;
            wd_cnt  <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state   <= ACTIVE;
                        owner   <= next_owner;
                        grant_o <= NUM_MASTERS'(1) << next_owner;
                        wd_cnt  <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!own_cyc) begin
                        state   <= IDLE;
                        last    <= owner;
                        grant_o <= '0;
                        wd_cnt  <= '0;
                        busy_o  <= 1'b0;
                    end else if (wd_hit) begin
                        state  <= ABORT;
                        wd_cnt <= '0;
                    end else if (own_stb && !slave_resp) begin
                        if (TIMEOUT != 0 && wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ABORT: begin
                    // The slave side stays dead until the owner gives up its cycle.
                    if (!own_cyc) begin
                        state   <= IDLE;
                        last    <= owner;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
